// File: rtl/vgachargen_pkg.sv
// Shared types and constants for the text-mode character generator.
// Holds glyph geometry, the attribute byte layout, the 4:4:4 colour type,
// the 16-entry CGA palette and the per-stage sideband record.
package vgachargen_pkg;

  localparam int GLYPH_W          = 8;
  localparam int GLYPH_H          = 16;
  localparam int CURSOR_FIRST_ROW = 14;

  // Matches ch_data[15:8] bit for bit.
  typedef struct packed {
    logic       blink;
    logic [2:0] bg;
    logic [3:0] fg;
  } attr_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam rgb444_t PALETTE [0:15] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  // Per-pixel data travelling alongside the memory lookups.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       cur;
    logic [3:0] glyph_row;
    logic [2:0] px;
  } side_t;

  // Syncs idle high so a reset never emits a spurious sync pulse.
  localparam side_t SIDE_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0,
                                 glyph_row: 4'd0, px: 3'd0};

endpackage

// File: rtl/blink_counter.sv
// Frame counter driving text blink and cursor flash.
// Counts falling edges of vsync_in; blink_phase is the counter MSB, so it
// toggles every BLINK_FRAMES frames.
// Ports: clk, rst (async, active-high), vsync_in (active-low), blink_phase.
module blink_counter #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic blink_phase
);

  localparam int CW = $clog2(BLINK_FRAMES) + 1;

  logic          vs_prev;
  logic [CW-1:0] cnt;

  // vs_prev resets low so a vsync already low at reset release is not
  // mistaken for a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in) cnt <= cnt + 1'b1;
    end
  end

  assign blink_phase = cnt[CW-1];

endmodule

// File: rtl/text_pixel_renderer.sv
// Text-mode pixel pipeline behind the VGA timing generator.
// Stage 1 forms the character address, character memory answers a clock
// later, the font ROM a clock after that, and the output stage applies
// palette, blink and cursor. Fixed 3-clk latency; syncs/de delayed to match.
// Ports: clk, rst (async, active-high); hpos/vpos/display_on/hsync_in/
// vsync_in from timing; ch_addr/ch_data character memory; font_addr/
// font_data font ROM; cursor_en/col/row; red/green/blue, hsync, vsync, de.
module text_pixel_renderer
  import vgachargen_pkg::*;
#(
  parameter int HPOS_WIDTH   = 10,
  parameter int VPOS_WIDTH   = 10,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  input  logic                  display_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic [11:0]           ch_addr,
  input  logic [15:0]           ch_data,
  output logic [11:0]           font_addr,
  input  logic [7:0]            font_data,
  input  logic                  cursor_en,
  input  logic [6:0]            cursor_col,
  input  logic [4:0]            cursor_row,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de
);

  logic [6:0] col;
  logic [4:0] row;
  logic       cursor_hit;
  logic       blink_phase;
  logic       pixel_on;
  rgb444_t    pix;
  side_t      s1, s2, s3;
  attr_t      attr3;
  logic       unused;

  assign col = hpos[9:3];
  assign row = vpos[8:4];
  assign unused = ^{vpos[VPOS_WIDTH-1:9]};

  // Range check keeps an off-screen cursor from lighting a blanking cell
  // that happens to share its column/row code.
  assign cursor_hit = cursor_en && (col == cursor_col) && (row == cursor_row)
                   && (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS);

  blink_counter #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst         (rst),
    .vsync_in    (vsync_in),
    .blink_phase (blink_phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= SIDE_RST;
      s2      <= SIDE_RST;
      s3      <= SIDE_RST;
      attr3   <= '0;
      ch_addr <= '0;
    end else begin
      s1 <= '{de: display_on, hs: hsync_in, vs: vsync_in, cur: cursor_hit,
              glyph_row: vpos[3:0], px: hpos[2:0]};
      // Blanking addresses park at 0 so the memory is never read out of range.
      ch_addr <= display_on ? 12'(int'(row) * COLS + int'(col)) : 12'd0;
      s2      <= s1;
      s3      <= s2;
      // ch_data belongs to the pixel now in s2; capture its attribute with it.
      attr3   <= attr_t'(ch_data[15:8]);
    end
  end

  assign font_addr = {ch_data[7:0], s2.glyph_row};

  always_comb begin
    pixel_on = font_data[3'd7 - s3.px];
    if (attr3.blink && !blink_phase) pixel_on = 1'b0;
    // Cursor wins over blink-off so it stays visible on blinking text.
    if (s3.cur && (s3.glyph_row >= 4'(CURSOR_FIRST_ROW)) && blink_phase)
      pixel_on = 1'b1;
    pix = PALETTE[pixel_on ? attr3.fg : {1'b0, attr3.bg}];
    if (!s3.de) pix = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
    end else begin
      red   <= pix.r;
      green <= pix.g;
      blue  <= pix.b;
      hsync <= s3.hs;
      vsync <= s3.vs;
      de    <= s3.de;
    end
  end

endmodule

// File: doc/text_pixel_renderer.md
Name: text_pixel_renderer

Overview:
- Text-mode pixel pipeline directly downstream of the VGA timing generator; consumes hpos/vpos/display_on/hsync/vsync and produces 4:4:4 RGB plus aligned syncs.
- Looks up character code and attribute in external character memory, then glyph row in external font ROM, then applies the palette, blink and hardware cursor.
- Fixed 3-clk latency; syncs are delayed by the same amount so they stay aligned with pixels. Timing generator's N_MIXER_PIPE_STAGES absorbs the offset.

Parameters:
- HPOS_WIDTH, 10, width of hpos.
- VPOS_WIDTH, 10, width of vpos.
- COLS, 80, text columns; ch_addr = row*COLS + col.
- ROWS, 30, text rows.
- BLINK_FRAMES, 32, frames per blink half-period; must be a power of 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- hpos  in  HPOS_WIDTH  pixel x from timing generator.
- vpos  in  VPOS_WIDTH  pixel y from timing generator.
- display_on  in  1  active-video flag.
- hsync_in  in  1  active-low hsync from timing generator.
- vsync_in  in  1  active-low vsync from timing generator.
- ch_addr  out  12  character memory address.
- ch_data  in  16  character memory read data, valid 1 clk after ch_addr: [7:0] code, [11:8] fg, [14:12] bg, [15] blink.
- font_addr  out  12  font ROM address {code[7:0], glyph_row[3:0]}.
- font_data  in  8  font ROM data, valid 1 clk after font_addr; bit 7 is the leftmost pixel.
- cursor_en  in  1  cursor enable.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- red, green, blue  out  4 each  pixel colour.
- hsync, vsync  out  1  delayed syncs, active-low.
- de  out  1  delayed display_on.

Behaviour:
- Reset (async): red/green/blue=0, de=0, hsync=vsync=1, ch_addr=0, all pipeline sideband registers cleared, frame counter=0.
- Pipeline runs every clk with no stall. Inputs are held for CLK/pixel-clock ratio cycles upstream; the block does not depend on that ratio.
- Edge E0: S1 registers col=hpos[9:3], row=vpos[8:4], glyph_row=vpos[3:0], px=hpos[2:0], de, hs, vs, cursor_hit.
  - ch_addr = row*COLS+col (12-bit) when display_on=1, else 0, so the address never exceeds COLS*ROWS-1.
  - cursor_hit = cursor_en && col==cursor_col && row==cursor_row.
- Edge E1: S2 delays sideband. font_addr is combinational = {ch_data[7:0], S2.glyph_row}.
- Edge E2: S3 registers attr=ch_data[15:8] (captured at E1 into S2) and delays sideband; font ROM output is valid after E2.
- Edge E3: output registers.
  - pixel_on = font_data[7-px].
  - When the blink attribute is set and blink_phase=0, pixel_on is forced to 0.
  - When cursor_hit, glyph_row is 14 or 15, and blink_phase=1, pixel_on is forced to 1.
  - rgb = de ? PALETTE[pixel_on ? fg : {1'b0,bg}] : 12'h000.
  - hsync/vsync/de outputs = S3 copies.
- Latency: input sampled at E0 appears on the outputs after E3 (3 clk). Syncs, de and rgb have identical latency.
- Blink counter: detect falling edge of vsync_in (registered previous value).
  - Counter is log2(BLINK_FRAMES)+1 bits and wraps.
  - blink_phase = MSB.
  - A falling edge coincident with reset release is ignored.
- Cursor row/col inputs are sampled at E0 and may change at any time; no glitch protection is needed beyond that.
- Out-of-range cursor (col>=COLS or row>=ROWS) never matches a visible cell.
- Reset mid-frame: outputs return to reset values immediately. After release, the first valid pixels appear 3 clk after the first sampled input.

Decomposition:
- Package vgachargen_pkg holds:
  - GLYPH_W=8 and GLYPH_H=16 constants.
  - Attribute typedef: struct blink, bg[2:0], fg[3:0].
  - rgb444_t.
  - 16-entry PALETTE constant (CGA colours, e.g. 0=000, 7=AAA, 15=FFF).
  - CURSOR_FIRST_ROW=14.
- One sub-module: blink_counter (vsync falling-edge detector plus wrapping counter; outputs blink_phase).

Test Plan:
- Reset held, then released with display_on=1 → red/green/blue=0, hsync=vsync=1, de=0 during reset; first non-zero pixel appears exactly 3 clk after first sampled input.
- hpos=8, vpos=16 → ch_addr=81. With ch_data=16'h0F41 and font_data=8'h80: px=0 gives rgb=FFF; px=1 gives bg colour 000.
- display_on=0 with hpos=700, vpos=500 → ch_addr=0, rgb=000; hsync_in low pulse reappears on hsync exactly 3 clk later.
- Blink: attr=8'h8F, BLINK_FRAMES=2 → lit glyph pixels are FFF for 2 vsync falling edges, then 000 for 2, repeating.
- Cursor: cursor_en=1, col=5, row=2, vpos=46 (glyph row 14), hpos in 40..47, blink_phase=1 → all 8 pixels are fg. With vpos=45 → font data only.
- Async reset asserted mid-line between clk edges → outputs go to reset values without waiting for clk; frame counter returns to 0.
